// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, issues in-order pipelined reads to imem and
// buffers returned words in a DEPTH-entry FIFO for decode. FETCH_BYPASS_EN adds an empty-FIFO bypass.
module fetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready
);
    // Handshakes: a transfer happens in any cycle where valid && ready are both high;
    // a raised valid keeps its payload stable until that transfer (only redirect may withdraw a request).
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CW-1:0]         in_flight;
    logic [CW-1:0]         stale;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

    logic [CW:0]           credits_used;
    logic                  req_fire;
    logic                  rsp_keep;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] target_pc;
    logic [1:0]            unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];
    assign target_pc           = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    // Words buffered plus live (non-stale) requests in flight may never exceed the FIFO size.
    assign credits_used   = {1'b0, count} + {1'b0, in_flight} - {1'b0, stale};
    assign imem_req_valid = !rst && !redirect && (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep   = imem_rsp_valid && (stale == '0);
    assign fifo_empty = (count == '0);
    assign pop        = !fifo_empty && instr_ready;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass      = fifo_empty && rsp_keep;
    assign instr_valid = !fifo_empty || bypass;
    assign instr       = bypass ? imem_rsp_data : data_mem[rd_ptr];
    assign instr_pc    = bypass ? resp_pc : pc_mem[rd_ptr];
    assign push        = rsp_keep && !(bypass && instr_ready);
`else
    assign instr_valid = !fifo_empty;
    assign instr       = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign push        = rsp_keep;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            in_flight <= '0;
            stale     <= '0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect) begin
            // Everything still in flight becomes stale; this cycle's response is dropped too.
            fetch_pc  <= target_pc;
            resp_pc   <= target_pc;
            stale     <= stale + in_flight - CW'(imem_rsp_valid);
            in_flight <= in_flight - CW'(imem_rsp_valid);
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
            in_flight <= in_flight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (stale != '0)) begin
                stale <= stale - CW'(1);
            end
            if (rsp_keep) begin
                resp_pc <= resp_pc + ADDR_WIDTH'(4);
            end
            if (push) begin
                data_mem[wr_ptr] <= imem_rsp_data;
                pc_mem[wr_ptr]   <= resp_pc;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            assert (!(push && !pop && (count == CW'(DEPTH))))
                else $error("fetch_queue: FIFO overflow");
        end
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage directly upstream of the decode stage; owns the PC and sources the 32-bit instruction word that decode consumes.
- Issues in-order, pipelined read requests to instruction memory and buffers returned words in a DEPTH-entry FIFO.
- Presents the words to decode with a valid/ready handshake.
- Accepts a branch/jump redirect that flushes the FIFO and discards in-flight responses.

Parameters:
- DATA_WIDTH, 32: instruction word width.
- ADDR_WIDTH, 32: PC / memory address width.
- DEPTH, 4: FIFO entries and maximum outstanding requests; power of two, at least 2.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  synchronous active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_WIDTH  request address, always word aligned.
- imem_rsp_valid  in  1  response valid. Responses are in order, arrive at least 1 cycle after acceptance, and cannot be back-pressured.
- imem_rsp_data  in  DATA_WIDTH  response instruction word.
- redirect  in  1  taken branch/jump from downstream.
- redirect_pc  in  ADDR_WIDTH  new fetch address; bits [1:0] are ignored and forced to 0.
- instr  out  DATA_WIDTH  instruction to decode (FIFO head).
- instr_pc  out  ADDR_WIDTH  PC of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts instr (not stalled).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_PC; FIFO empty.
  - in_flight = 0; stale = 0.
  - imem_req_valid = 0; instr_valid = 0.
  - instr and instr_pc are don't-care while invalid; driven 0 after reset.
- Reset mid-operation: all state is cleared, and responses already in flight are lost. The memory must be reset in the same cycle.
- Counters:
  - in_flight counts accepted, unreturned requests (including stale ones).
  - stale counts responses to discard.
  - Both are $clog2(DEPTH+1) bits wide.
- Request issue:
  - imem_req_valid = !rst && !redirect && (count + in_flight - stale) < DEPTH.
  - imem_req_addr = fetch_pc.
  - On handshake (valid & ready): fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH), in_flight += 1.
  - Address and valid stay stable until the handshake. The one exception: redirect may withdraw the request in the cycle it is asserted.
- Response:
  - On imem_rsp_valid: in_flight -= 1.
  - If stale > 0: stale -= 1 and the data is dropped.
  - Otherwise push {data, pc}. The pushed pc comes from a resp_pc register that advances by 4 per non-stale response.
  - FIFO overflow cannot occur because of the credit rule. An overflow is an assertion failure in simulation.
- Output:
  - instr_valid = (count != 0).
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle are legal at any occupancy, including full.
- Latency: minimum 2 cycles from request acceptance to instr_valid (memory latency 1 plus FIFO register). Sustained throughput is 1 instruction/cycle when memory latency is at most DEPTH-1.
- Redirect (highest priority over everything except rst):
  - FIFO is flushed; any pop in that cycle is ignored.
  - fetch_pc and resp_pc are loaded with {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - stale_next = stale + in_flight - (imem_rsp_valid ? 1 : 0); the response arriving that cycle is dropped.
  - If imem_req_ready was high that cycle, no request is counted, because valid is 0.
  - The first request to the new PC is issued the next cycle.
- Back-to-back redirects: each one re-flushes and recomputes stale with the same rule.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- When defined:
  - If the FIFO is empty and a non-stale response arrives, instr/instr_pc/instr_valid are driven combinationally from the response in the same cycle.
  - If instr_ready is high, the word is consumed without being written.
  - Minimum latency becomes 1 cycle.
- When undefined: every word goes through the FIFO register, giving a minimum latency of 2 cycles and no combinational path from imem_rsp_* to instr*.

Test Plan:
- Reset release, memory latency 1, instr_ready=1 -> requests at 0x0,0x4,0x8...; instr_valid first high 2 cycles after the first handshake; instr_pc sequence 0x0,0x4,0x8 with matching data.
- instr_ready=0 for 20 cycles, latency 1 -> exactly 4 requests accepted, FIFO full, imem_req_valid=0; releasing ready drains 0x0..0xC in order with no loss or duplication.
- 3 requests in flight (0x0,0x4,0x8), redirect to 0x103 -> next request addr 0x100; the 3 old responses are discarded; first instr_pc delivered is 0x100.
- Redirect in the same cycle as a response and a pop, with 2 in flight -> that response is dropped, stale=1, FIFO empty next cycle, no instr_valid until the 0x... redirect target returns.
- imem_req_ready held low for 5 cycles -> imem_req_valid high with imem_req_addr constant; fetch_pc advances only on the handshake.
- Set fetch near the top of the address space (redirect to 0xFFFF_FFF8) -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst asserted mid-stream -> all outputs return to reset values next cycle.
